// File: rtl/rsb_pkg.sv
// Shared types and constants for the register scoreboard.
package rsb_pkg;
  localparam int AW    = 4;
  localparam int LAT_W = 2;
  localparam int NREGS = 16;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [LAT_W-1:0] lat_t;

  localparam reg_addr_t REG_ZERO = '0;

  // A latency of zero is not meaningful and is promoted to one cycle.
  function automatic lat_t eff_lat(input lat_t l);
    return (l == '0) ? lat_t'(1) : l;
  endfunction
endpackage

// File: rtl/rsb_entry.sv
// Per-register pending-write counter: load on a new write, else count down to zero.
module rsb_entry
  import rsb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  lat_t lat_i,
  output lat_t cnt_o,
  output logic busy_o
);

  lat_t cnt_q, cnt_d;

  // A new write overrides the running countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (set_i)
      cnt_d = lat_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - lat_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: RAW/WAW stall and operand forward selects.
// Define RSB_FORWARD_EN to forward results whose counter has reached one.
module reg_scoreboard
  import rsb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  reg_addr_t        issue_dst,
  input  lat_t             issue_lat,
  input  reg_addr_t        src_a,
  input  reg_addr_t        src_b,
  input  logic             src_a_used,
  input  logic             src_b_used,
  input  logic             flush,
  output logic             stall,
  output logic             fwd_sel_a,
  output logic             fwd_sel_b,
  output logic [NREGS-1:0] busy_mask
);

  lat_t             cnt [NREGS];
  logic [NREGS-1:0] busy;
  lat_t             lat_eff;
  logic             accept;
  logic             wr_en;
  logic             rd_a, rd_b;
  logic             hazard_a, hazard_b, waw;

  assign lat_eff = eff_lat(issue_lat);
  assign accept  = issue_valid && !stall && !flush;
  assign wr_en   = accept && issue_wen && (issue_dst != REG_ZERO);

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_entry
      rsb_entry u_entry (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (wr_en && (issue_dst == reg_addr_t'(gi))),
        .lat_i  (lat_eff),
        .cnt_o  (cnt[gi]),
        .busy_o (busy[gi])
      );
    end
  endgenerate

  assign rd_a = src_a_used && (src_a != REG_ZERO);
  assign rd_b = src_b_used && (src_b != REG_ZERO);

  // Hazard checks see pre-update counters, so an instruction never waits on itself.
`ifdef RSB_FORWARD_EN
  assign hazard_a  = rd_a && (cnt[src_a] > lat_t'(1));
  assign hazard_b  = rd_b && (cnt[src_b] > lat_t'(1));
  assign fwd_sel_a = rd_a && (cnt[src_a] == lat_t'(1)) && !stall;
  assign fwd_sel_b = rd_b && (cnt[src_b] == lat_t'(1)) && !stall;
`else
  assign hazard_a  = rd_a && (cnt[src_a] != '0);
  assign hazard_b  = rd_b && (cnt[src_b] != '0);
  assign fwd_sel_a = 1'b0;
  assign fwd_sel_b = 1'b0;
`endif

  // A younger, shorter write must not complete before an older one to the same register.
  assign waw   = issue_wen && (cnt[issue_dst] > lat_eff);
  assign stall = issue_valid && !flush && (hazard_a || hazard_b || waw);

  assign busy_mask = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard; works with or without RSB_FORWARD_EN.
module tb_reg_scoreboard;
  import rsb_pkg::*;

`ifdef RSB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wen, src_a_used, src_b_used, flush;
  logic [3:0]  issue_dst, src_a, src_b;
  logic [1:0]  issue_lat;
  logic        stall, fwd_sel_a, fwd_sel_b;
  logic [15:0] busy_mask;

  typedef struct {
    logic        stall;
    logic        fa;
    logic        fb;
    logic [15:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   m [16];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_dst   (issue_dst),
    .issue_lat   (issue_lat),
    .src_a       (src_a),
    .src_b       (src_b),
    .src_a_used  (src_a_used),
    .src_b_used  (src_b_used),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .busy_mask   (busy_mask)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] l);
    return (l == 2'd0) ? 1 : int'(l);
  endfunction

  function automatic bit model_haz(input logic [3:0] s, input logic u);
    if (!u || s == 4'd0 || m[s] == 0) return 1'b0;
    return FWD ? (m[s] >= 2) : 1'b1;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   waw;
    waw     = issue_wen && (m[issue_dst] > lat_of(issue_lat));
    e.stall = issue_valid && !flush &&
              (model_haz(src_a, src_a_used) || model_haz(src_b, src_b_used) || waw);
    e.fa    = FWD && src_a_used && src_a != 4'd0 && m[src_a] == 1 && !e.stall;
    e.fb    = FWD && src_b_used && src_b != 4'd0 && m[src_b] == 1 && !e.stall;
    e.busy  = '0;
    for (int r = 1; r < 16; r++) e.busy[r] = (m[r] != 0);
    return e;
  endfunction

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle_io(input string tag, input logic v, input logic wen, input logic [3:0] dst,
                          input logic [1:0] lat, input logic [3:0] sa, input logic ua,
                          input logic [3:0] sb, input logic ub, input logic fl, output logic st);
    exp_t e, got;
    bit   acc;
    issue_valid = v;  issue_wen = wen; issue_dst = dst; issue_lat = lat;
    src_a = sa; src_a_used = ua; src_b = sb; src_b_used = ub; flush = fl;
    #1;
    e = predict();
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    check_val({tag, "_stall"}, 32'(stall), 32'(got.stall));
    check_val({tag, "_fwd_a"}, 32'(fwd_sel_a), 32'(got.fa));
    check_val({tag, "_fwd_b"}, 32'(fwd_sel_b), 32'(got.fb));
    check_val({tag, "_busy"}, 32'(busy_mask), 32'(got.busy));
    st = stall;
    @(posedge clk);
    acc = v && !got.stall && !fl;
    for (int r = 1; r < 16; r++) begin
      if (acc && wen && dst == 4'(r)) m[r] = lat_of(lat);
      else if (m[r] != 0) m[r] = m[r] - 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) cycle_io("idle", 0, 0, 4'd0, 2'd0, 4'd0, 0, 4'd0, 0, 0, st);
  endtask

  task automatic issue_op(input string tag, input logic wen, input logic [3:0] dst, input logic [1:0] lat,
                          input logic [3:0] sa, input logic ua, input logic [3:0] sb, input logic ub,
                          output int nst);
    logic st;
    nst = 0;
    st  = 1'b1;
    for (int i = 0; i < 8 && st; i++) begin
      cycle_io(tag, 1, wen, dst, lat, sa, ua, sb, ub, 0, st);
      if (st) nst++;
    end
    if (st) check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int   nst;
    logic st;
    rst_n = 1'b0;
    issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_lat = 0;
    src_a = 0; src_b = 0; src_a_used = 0; src_b_used = 0; flush = 0;
    for (int r = 0; r < 16; r++) m[r] = 0;
    #2;
    check_val("reset_stall", 32'(stall), 32'd0);
    check_val("reset_busy", 32'(busy_mask), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    idle(5);

    // RAW on R3 with latency 2
    issue_op("raw_prod", 1, 4'd3, 2'd2, 4'd0, 0, 4'd0, 0, nst);
    issue_op("raw_cons", 0, 4'd0, 2'd1, 4'd3, 1, 4'd0, 0, nst);
    check_val("raw_stalls", 32'(nst), FWD ? 32'd1 : 32'd2);
    idle(4);

    // Long latency on R5 through src_b
    issue_op("long_prod", 1, 4'd5, 2'd3, 4'd0, 0, 4'd0, 0, nst);
    issue_op("long_cons", 0, 4'd0, 2'd1, 4'd0, 0, 4'd5, 1, nst);
    check_val("long_stalls", 32'(nst), FWD ? 32'd2 : 32'd3);
    idle(4);

    // WAW on R7: latency 3 then latency 1
    issue_op("waw_old", 1, 4'd7, 2'd3, 4'd0, 0, 4'd0, 0, nst);
    issue_op("waw_new", 1, 4'd7, 2'd1, 4'd0, 0, 4'd0, 0, nst);
    check_val("waw_stalls", 32'(nst), 32'd2);
    idle(3);

    // Write to R0 is never tracked; reading R0 never stalls
    issue_op("r0_wr", 1, 4'd0, 2'd3, 4'd0, 0, 4'd0, 0, nst);
    issue_op("r0_rd", 0, 4'd0, 2'd1, 4'd0, 1, 4'd0, 1, nst);
    check_val("r0_stalls", 32'(nst), 32'd0);
    check_val("r0_busy", 32'(busy_mask), 32'd0);

    // Self-dependency, same-source and flush with a live hazard
    issue_op("self_dep", 1, 4'd9, 2'd3, 4'd9, 1, 4'd9, 1, nst);
    check_val("self_stalls", 32'(nst), 32'd0);
    cycle_io("flush", 1, 1, 4'd9, 2'd1, 4'd9, 1, 4'd9, 1, 1, st);
    check_val("flush_stall", 32'(st), 32'd0);
    check_val("flush_busy", 32'(busy_mask), 32'h0200);
    idle(4);

    // Asynchronous reset while stalled
    issue_op("ar_prod", 1, 4'd4, 2'd3, 4'd0, 0, 4'd0, 0, nst);
    issue_valid = 1; issue_wen = 0; src_a = 4'd4; src_a_used = 1; src_b_used = 0; flush = 0;
    #1 check_val("ar_pre_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("ar_stall", 32'(stall), 32'd0);
    check_val("ar_busy", 32'(busy_mask), 32'd0);
    check_val("ar_fwd_a", 32'(fwd_sel_a), 32'd0);
    for (int r = 0; r < 16; r++) m[r] = 0;
    issue_valid = 0; src_a_used = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Randomised traffic on a small register window
    for (int i = 0; i < 300; i++) begin
      cycle_io("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
